dedup_sequencer: RTL

//  Controller that sequences an in-place "remove duplicates from sorted array" pass over a memory.
//  It reads elements 0..len-1 from a source memory, one per cycle.
//  It writes each element that differs from its predecessor to a destination memory at a compacted index.
//  It reports the unique count k when the pass finishes.
//  It sits between a request source (start/len) and a pair of 1-cycle-latency SRAM ports.

---
 rtl/dedup_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/dedup_sequencer.sv
// rtl/dedup_sequencer.sv - sequences a remove-duplicates pass from a source SRAM into a compacted destination SRAM
module dedup_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   k,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   i;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   j;
    logic [DATA_W-1:0] prev;
    logic              vld;
    logic              first;
    logic              keep;
    logic [ADDR_W:0]   len_clamp;

    assign len_clamp = (len > MAX_LEN) ? MAX_LEN : len;

    // vld marks the cycle where rd_data belongs to the previous cycle's read
    assign keep    = vld && (first || (rd_data != prev));
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    assign rd_en   = (state == SCAN);
    assign rd_addr = (state == SCAN) ? i[ADDR_W-1:0] : '0;
    assign wr_en   = keep;
    assign wr_addr = keep ? j[ADDR_W-1:0] : '0;
    assign wr_data = vld ? rd_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_clamp == '0) ? FINISH : SCAN;
                end
            end
            SCAN: begin
                if ((i + ONE) == len_q) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            i     <= '0;
            len_q <= '0;
            j     <= '0;
            k     <= '0;
            prev  <= '0;
            vld   <= 1'b0;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            vld   <= (state == SCAN);
            first <= (state == SCAN) && (i == '0);
            if (vld) begin
                prev <= rd_data;
            end
            if (keep) begin
                j <= j + ONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len_clamp;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                    end
                end
                SCAN: begin
                    i <= i + ONE;
                end
                DRAIN: begin
                    // final element is compared here, so fold its keep into k
                    k <= keep ? (j + ONE) : j;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
